// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: instruction formats, major opcodes and the
// bit positions of the fixed instruction fields (shared with the decoder).
package rv32_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;

   localparam int unsigned OPCODE_LSB = 0;
   localparam int unsigned RD_LSB     = 7;
   localparam int unsigned FUNCT3_LSB = 12;
   localparam int unsigned RS1_LSB    = 15;
   localparam int unsigned RS2_LSB    = 20;
   localparam int unsigned FUNCT7_LSB = 25;

   function automatic logic fmt_is_valid(input logic [2:0] fmt_v);
      return (fmt_v <= FMT_J);
   endfunction

endpackage

// File: rtl/rv32_instr_fifo.sv
// Synchronous FIFO with combinational head read; push when full and pop
// when empty are ignored. DEPTH must be a power of two.
module rv32_instr_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_s && !rst) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/rv32_instr_encoder.sv
// Packs RV32I field sets into instruction words, holds one encoded word in
// an encode register, then queues it in the instruction FIFO.
module rv32_instr_encoder
   import rv32_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       fmt,
   input  logic [6:0]       opcode,
   input  logic [4:0]       rd,
   input  logic [2:0]       funct3,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [6:0]       funct7,
   input  logic [WIDTH-1:0] imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_instr,
   output logic [AW:0]      count,
   output logic             fmt_err
);

   logic [WIDTH-1:0] enc_word_q, enc_word_d;
   logic             enc_valid_q, enc_valid_d;
   logic             fmt_err_q, fmt_err_d;
   logic             full_s;
   logic             empty_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic             fmt_ok_s;

   function automatic logic [31:0] pack_instr(
      input logic [2:0]  fmt_v,
      input logic [6:0]  opcode_v,
      input logic [4:0]  rd_v,
      input logic [2:0]  funct3_v,
      input logic [4:0]  rs1_v,
      input logic [4:0]  rs2_v,
      input logic [6:0]  funct7_v,
      input logic [31:0] imm_v
   );
      logic [31:0] w;
      w = 32'h0000_0000;
      w[OPCODE_LSB +: 7] = opcode_v;
      case (fmt_v)
         FMT_R: begin
            w[RD_LSB +: 5]     = rd_v;
            w[FUNCT3_LSB +: 3] = funct3_v;
            w[RS1_LSB +: 5]    = rs1_v;
            w[RS2_LSB +: 5]    = rs2_v;
            w[FUNCT7_LSB +: 7] = funct7_v;
         end
         FMT_I: begin
            w[RD_LSB +: 5]     = rd_v;
            w[FUNCT3_LSB +: 3] = funct3_v;
            w[RS1_LSB +: 5]    = rs1_v;
            w[31:20]           = imm_v[11:0];
         end
         FMT_S: begin
            w[11:7]            = imm_v[4:0];
            w[FUNCT3_LSB +: 3] = funct3_v;
            w[RS1_LSB +: 5]    = rs1_v;
            w[RS2_LSB +: 5]    = rs2_v;
            w[31:25]           = imm_v[11:5];
         end
         FMT_B: begin
            // Branch offsets are halfword aligned, so imm[0] is dropped.
            w[7]               = imm_v[11];
            w[11:8]            = imm_v[4:1];
            w[FUNCT3_LSB +: 3] = funct3_v;
            w[RS1_LSB +: 5]    = rs1_v;
            w[RS2_LSB +: 5]    = rs2_v;
            w[30:25]           = imm_v[10:5];
            w[31]              = imm_v[12];
         end
         FMT_U: begin
            w[RD_LSB +: 5]     = rd_v;
            w[31:12]           = imm_v[31:12];
         end
         FMT_J: begin
            w[RD_LSB +: 5]     = rd_v;
            w[19:12]           = imm_v[19:12];
            w[20]              = imm_v[11];
            w[30:21]           = imm_v[10:1];
            w[31]              = imm_v[20];
         end
         default: begin
            w = 32'h0000_0000;
         end
      endcase
      return w;
   endfunction

   assign fmt_ok_s  = fmt_is_valid(fmt);
   assign in_ready  = !enc_valid_q || !full_s;
   assign accept_s  = in_valid && in_ready;
   assign push_s    = enc_valid_q && !full_s;
   assign pop_s     = out_valid && out_ready;
   assign out_valid = !empty_s;
   assign fmt_err   = fmt_err_q;

   // An invalid format completes the handshake but never occupies the encode register.
   always_comb begin
      enc_word_d  = enc_word_q;
      enc_valid_d = enc_valid_q;
      fmt_err_d   = 1'b0;
      if (accept_s && fmt_ok_s) begin
         enc_word_d  = pack_instr(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm);
         enc_valid_d = 1'b1;
      end else if (push_s) begin
         enc_valid_d = 1'b0;
      end else begin
         enc_valid_d = enc_valid_q;
      end
      fmt_err_d = accept_s && !fmt_ok_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enc_word_q  <= '0;
         enc_valid_q <= 1'b0;
         fmt_err_q   <= 1'b0;
      end else begin
         enc_word_q  <= enc_word_d;
         enc_valid_q <= enc_valid_d;
         fmt_err_q   <= fmt_err_d;
      end
   end

   rv32_instr_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i (enc_word_q),
      .rdata_o (out_instr),
      .full_o  (full_s),
      .empty_o (empty_s),
      .count_o (count)
   );

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Scoreboard bench: expected words are queued when a field set is accepted
// and compared in order as the FIFO delivers them.
module tb_rv32_instr_encoder;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       fmt;
   logic [6:0]       opcode;
   logic [4:0]       rd;
   logic [2:0]       funct3;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic [6:0]       funct7;
   logic [WIDTH-1:0] imm;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_instr;
   logic [AW:0]      count;
   logic             fmt_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   rv32_instr_encoder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
      .rs2(rs2), .funct7(funct7), .imm(imm), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .count(count),
      .fmt_err(fmt_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
         input logic [4:0] d, input logic [2:0] f3, input logic [4:0] s1,
         input logic [4:0] s2, input logic [6:0] f7, input logic [31:0] im);
      case (f)
         3'd0: return {f7, s2, s1, f3, d, op};
         3'd1: return {im[11:0], s1, f3, d, op};
         3'd2: return {im[11:5], s2, s1, f3, im[4:0], op};
         3'd3: return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
         3'd4: return {im[31:12], d, op};
         3'd5: return {im[20], im[10:1], im[11], im[19:12], d, op};
         default: return 32'h0;
      endcase
   endfunction

   // Inputs change 1ns after posedge, so at negedge they show what the next edge will do.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (in_valid && in_ready && fmt <= 3'd5)
            exp_q.push_back(ref_encode(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm));
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_unexpected got=%08h expected=none", out_instr);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (out_instr !== e) begin
                  errors++;
                  $display("FAIL scoreboard_word got=%08h expected=%08h", out_instr, e);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
         input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
         input logic [6:0] f7, input logic [31:0] im);
      logic got;
      fmt = f; opcode = op; rd = d; funct3 = f3; rs1 = s1; rs2 = s2; funct7 = f7; imm = im;
      in_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = in_ready;
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL send_timeout got=no_accept expected=accept");
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 300 && (exp_q.size() != 0 || out_valid); i++) step();
      checks++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty got=q%0d/v%b expected=q0/v0", exp_q.size(), out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      fmt = 3'd0; opcode = 7'h0; rd = 5'h0; funct3 = 3'h0; rs1 = 5'h0; rs2 = 5'h0;
      funct7 = 7'h0; imm = 32'h0;
      step(); step();
      rst = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 6'd0 || fmt_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got=r%b v%b c%0d e%b expected=r1 v0 c0 e0",
                  in_ready, out_valid, count, fmt_err);
      end
   endtask

   task automatic test_directed();
      logic [2:0]  t_f   [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
      logic [6:0]  t_op  [6] = '{7'h33, 7'h13, 7'h23, 7'h63, 7'h37, 7'h6F};
      logic [4:0]  t_rd  [6] = '{5'd3, 5'd5, 5'h1F, 5'h1F, 5'd1, 5'd1};
      logic [2:0]  t_f3  [6] = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd7, 3'd7};
      logic [4:0]  t_s1  [6] = '{5'd1, 5'd0, 5'd1, 5'd0, 5'h1F, 5'h1F};
      logic [4:0]  t_s2  [6] = '{5'd2, 5'h1F, 5'd2, 5'd0, 5'h1F, 5'h1F};
      logic [6:0]  t_f7  [6] = '{7'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
      logic [31:0] t_imm [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd8, 32'hFFFFFFFC,
                                 32'h12345000, 32'h00000800};
      logic [31:0] t_exp [6] = '{32'h002081B3, 32'hFFF00293, 32'h0020A423, 32'hFE000EE3,
                                 32'h123450B7, 32'h001000EF};
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         send(t_f[k], t_op[k], t_rd[k], t_f3[k], t_s1[k], t_s2[k], t_f7[k], t_imm[k]);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early fmt=%0d got=%b expected=0", k, out_valid);
         end
         step();
         checks++;
         if (out_valid !== 1'b1 || out_instr !== t_exp[k]) begin
            errors++;
            $display("FAIL directed_word fmt=%0d got=v%b %08h expected=v1 %08h",
                     k, out_valid, out_instr, t_exp[k]);
         end
         step();
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 24; k++) begin
         out_ready = 1'($urandom_range(0, 1));
         send(3'($urandom_range(0, 5)), 7'($urandom), 5'($urandom), 3'($urandom),
              5'($urandom), 5'($urandom), 7'($urandom), $urandom);
      end
      drain();
   endtask

   task automatic test_fill();
      int acc = 0;
      out_ready = 1'b0;
      fmt = 3'd1; opcode = 7'h13; rd = 5'd7; funct3 = 3'd0; rs1 = 5'd2;
      imm = 32'd0;
      in_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (in_ready) acc++;
         step();
         imm = 32'(k + 1);
      end
      in_valid = 1'b0;
      checks++;
      if (acc != 33 || count !== 6'd32 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill got=acc%0d c%0d r%b expected=acc33 c32 r0", acc, count, in_ready);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (count !== 6'd31 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL drain_one got=c%0d r%b expected=c31 r1", count, in_ready);
      end
      step();
      checks++;
      if (count !== 6'd32) begin
         errors++;
         $display("FAIL held_word_push got=%0d expected=32", count);
      end
      drain();
   endtask

   task automatic test_fmt_err();
      out_ready = 1'b1;
      for (int k = 6; k < 8; k++) begin
         send(3'(k), 7'h33, 5'd1, 3'd0, 5'd1, 5'd1, 7'd0, 32'h0);
         checks++;
         if (fmt_err !== 1'b1 || count !== 6'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fmt_err_pulse fmt=%0d got=e%b c%0d v%b expected=e1 c0 v0",
                     k, fmt_err, count, out_valid);
         end
         step();
         checks++;
         if (fmt_err !== 1'b0 || count !== 6'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fmt_err_clear fmt=%0d got=e%b c%0d v%b expected=e0 c0 v0",
                     k, fmt_err, count, out_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) send(3'd4, 7'h37, 5'(k), 3'd0, 5'd0, 5'd0, 7'd0, 32'(k) << 12);
      checks++;
      if (count !== 6'd5) begin
         errors++;
         $display("FAIL pre_reset_count got=%0d expected=5", count);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (count !== 6'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got=c%0d v%b r%b expected=c0 v0 r1", count, out_valid, in_ready);
      end
      step(); step();
      checks++;
      if (count !== 6'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL enc_discarded got=c%0d v%b expected=c0 v0", count, out_valid);
      end
      out_ready = 1'b1;
      send(3'd5, 7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFF8);
      drain();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_fill();
      test_fmt_err();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
